// File: rtl/fpga_template_pkg.sv
// Shared types and helpers for the FPGA template blocks.
// Holds the debug UART transmitter state encoding and sizing.
package fpga_template_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } dbg_tx_state_t;

  localparam int DBG_TX_FIFO_DEPTH = 16;

  function automatic int clks_per_bit(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/debug_tx_fifo.sv
// Single-clock byte FIFO for the debug transmitter.
// A push into a full FIFO is accepted only when a pop frees a slot.
module debug_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [7:0]       i_data,
  input  logic             i_pop,
  output logic [7:0]       o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [LVL_W-1:0] o_level,
  output logic             o_drop
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [LVL_W-1:0] r_level;

  logic w_full;
  logic w_empty;
  logic w_wr;
  logic w_rd;

  assign w_full  = (r_level == LVL_W'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_rd    = i_pop && !w_empty;
  assign w_wr    = i_push && (!w_full || w_rd);

  assign o_data  = r_mem[r_rptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_level = r_level;
  assign o_drop  = i_push && w_full && !w_rd;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + PTR_W'(1);
      if (w_rd) r_rptr <= r_rptr + PTR_W'(1);
      unique case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/debug_uart_tx.sv
// Buffered 8N1 transmitter for the debug byte stream.
// Bytes queue in a FIFO and leave LSB-first on a registered TX pin.
module debug_uart_tx
  import fpga_template_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 27_000_000,
  parameter int BAUD         = 115_200,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD),
  parameter int FIFO_DEPTH   = DBG_TX_FIFO_DEPTH,
  parameter int LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             send_valid,
  input  logic [7:0]       send_data,
  input  logic             overflow_clr,
  output logic             uart_tx,
  output logic             busy,
  output logic             fifo_full,
  output logic [LVL_W-1:0] fifo_level,
  output logic             overflow
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(CLKS_PER_BIT - 1);

  dbg_tx_state_t    r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_tx;
  logic             r_ovf;

  logic             w_empty;
  logic             w_full;
  logic             w_drop;
  logic             w_pop;
  logic             w_done;
  logic [7:0]       w_rdata;
  logic [LVL_W-1:0] w_level;

  debug_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (resetb),
    .i_push  (send_valid),
    .i_data  (send_data),
    .i_pop   (w_pop),
    .o_data  (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level),
    .o_drop  (w_drop)
  );

  assign w_done = (r_cnt == '0);
  assign w_pop  = !w_empty &&
    ((r_state == TX_IDLE) ||
     (r_state == TX_STOP && w_done));

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state <= TX_IDLE;
      r_cnt   <= CNT_LAST;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      unique case (r_state)
        TX_IDLE: begin
          r_tx  <= 1'b1;
          r_cnt <= CNT_LAST;
          if (w_pop) begin
            r_shift <= w_rdata;
            r_tx    <= 1'b0;
            r_state <= TX_START;
          end
        end
        TX_START: begin
          if (w_done) begin
            r_cnt   <= CNT_LAST;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= TX_DATA;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        TX_DATA: begin
          if (w_done) begin
            r_cnt <= CNT_LAST;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= TX_STOP;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        TX_STOP: begin
          if (w_done) begin
            r_cnt <= CNT_LAST;
            // Chain straight into the next start bit: no idle gap
            if (w_pop) begin
              r_shift <= w_rdata;
              r_tx    <= 1'b0;
              r_state <= TX_START;
            end else begin
              r_state <= TX_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (overflow_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign uart_tx    = r_tx;
  assign overflow   = r_ovf;
  assign fifo_full  = w_full;
  assign fifo_level = w_level;
  assign busy       = (r_state != TX_IDLE) || (w_level != '0);

endmodule
